// File: rtl/bcd_decode_sequencer.sv
// Scan sequencer for a 4-to-10 BCD decoder with active-low one-hot check.
// Optional macro SEQ_BLANK_EN: blank bcd_out (4'hF) when returning to IDLE.
module bcd_decode_sequencer #(
    parameter int DWELL = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] first,
    input  logic [3:0] last,
    input  logic       stop,
    output logic [3:0] bcd_out,
    input  logic [9:0] dec_n,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] err_digit
);

    localparam int CW = $clog2(DWELL);
    localparam logic [CW-1:0] CNT_END = CW'(DWELL - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [3:0]    r_bcd;
    logic [3:0]    r_last;
    logic [CW-1:0] r_cnt;
    logic          r_err;
    logic [3:0]    r_err_digit;

    logic          w_dwell_end;
    logic [9:0]    w_exp_n;
    logic          w_mismatch;
    logic          w_bad_param;
    logic [3:0]    w_next_bcd;

    // Dwell-end detect, expected decoder pattern and next digit with 9->0 wrap
    always_comb begin
        w_dwell_end = (r_cnt == CNT_END);
        w_exp_n     = ~(10'b1 << r_bcd);
        w_mismatch  = (dec_n != w_exp_n);
        w_bad_param = (first > 4'd9) || (last > 4'd9);
        w_next_bcd  = (r_bcd == 4'd9) ? 4'd0 : r_bcd + 4'd1;
    end

    // Scan FSM with dwell counter, digit stepping and sticky error capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_bcd       <= 4'hF;
            r_last      <= 4'h0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_err_digit <= 4'h0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_last      <= last;
                        r_err       <= w_bad_param;
                        r_err_digit <= w_bad_param ? 4'hF : 4'h0;
                        if (w_bad_param) begin
                            r_state <= S_DONE;
                        end else begin
                            r_bcd   <= first;
                            r_cnt   <= '0;
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                        if (w_dwell_end) begin
                            if (w_mismatch && !r_err) begin
                                r_err       <= 1'b1;
                                r_err_digit <= r_bcd;
                            end
                            if (r_bcd == r_last) begin
                                r_state <= S_DONE;
                            end else begin
                                r_bcd <= w_next_bcd;
                                r_cnt <= '0;
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
`ifdef SEQ_BLANK_EN
                    r_bcd   <= 4'hF;
`endif
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bcd_out   = r_bcd;
    assign busy      = (r_state == S_RUN);
    assign done      = (r_state == S_DONE);
    assign err       = r_err;
    assign err_digit = r_err_digit;

endmodule

// File: tb/tb_bcd_decode_sequencer.sv
// Self-checking bench for bcd_decode_sequencer with a behavioural decoder.
// Expected per-cycle digit/err values are queued when a scan is started.
module tb_bcd_decode_sequencer;

    localparam int DWELL = 4;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] first;
    logic [3:0] last;
    logic       stop;
    logic [3:0] bcd_out;
    logic [9:0] dec_n;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] err_digit;

    logic       stuck5;
    logic [9:0] dec_ideal;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] d;
        logic       e;
    } exp_t;

    exp_t exp_q[$];

    bcd_decode_sequencer #(.DWELL(DWELL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .first     (first),
        .last      (last),
        .stop      (stop),
        .bcd_out   (bcd_out),
        .dec_n     (dec_n),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_digit (err_digit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural decoder; optional fault holds output 5 inactive
    always_comb begin
        dec_ideal = (bcd_out <= 4'd9) ? ~(10'd1 << bcd_out) : 10'h3FF;
        dec_n     = stuck5 ? (dec_ideal | 10'b0000100000) : dec_ideal;
    end

`ifdef SEQ_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        first = 4'h0;
        last  = 4'h0;
        stuck5 = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bcd_out !== 4'hF || busy !== 1'b0 || done !== 1'b0 ||
            err !== 1'b0 || err_digit !== 4'h0) begin
            errors++;
            $display("FAIL reset: bcd=%h busy=%b done=%b err=%b ed=%h want F 0 0 0 0",
                     bcd_out, busy, done, err, err_digit);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Runs one scan; returns at the negedge where done is observed
    task automatic run_scan(input logic [3:0] f, input logic [3:0] l,
                            input bit stk, input bit post);
        int   n;
        int   ncyc;
        int   d;
        bit   seen;
        exp_t x;
        exp_q.delete();
        stuck5 = stk;
        seen = 1'b0;
        d = f;
        n = 0;
        forever begin
            for (int k = 0; k < DWELL; k++) begin
                x.d = 4'(d);
                x.e = seen;
                exp_q.push_back(x);
            end
            n++;
            if (stk && d == 5) seen = 1'b1;
            if (d == int'(l)) break;
            d = (d == 9) ? 0 : d + 1;
        end
        start = 1'b1;
        first = f;
        last  = l;
        @(negedge clk);
        start = 1'b0;
        ncyc = 0;
        while (!done && ncyc < 200) begin
            if (busy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scan_extra: cycle %0d bcd=%h queue empty",
                             ncyc, bcd_out);
                end else begin
                    x = exp_q.pop_front();
                    checks++;
                    if (bcd_out !== x.d || err !== x.e) begin
                        errors++;
                        $display("FAIL scan_step %0d: bcd=%h err=%b want %h %b",
                                 ncyc, bcd_out, err, x.d, x.e);
                    end
                end
            end
            ncyc++;
            @(negedge clk);
        end
        checks++;
        if (!done || busy || ncyc != n * DWELL || exp_q.size() != 0) begin
            errors++;
            $display("FAIL scan_len %h..%h: done=%b busy=%b cycles=%0d want %0d",
                     f, l, done, busy, ncyc, n * DWELL);
        end
        checks++;
        if (err !== seen || err_digit !== (seen ? 4'd5 : 4'd0) ||
            bcd_out !== l) begin
            errors++;
            $display("FAIL scan_end %h..%h: err=%b ed=%h bcd=%h want %b %h %h",
                     f, l, err, err_digit, bcd_out, seen,
                     seen ? 4'd5 : 4'd0, l);
        end
        if (post) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || err !== seen ||
                err_digit !== (seen ? 4'd5 : 4'd0) ||
                bcd_out !== (BLANK ? 4'hF : l)) begin
                errors++;
                $display("FAIL scan_idle: done=%b err=%b ed=%h bcd=%h want 0 %b %h %h",
                         done, err, err_digit, bcd_out, seen,
                         seen ? 4'd5 : 4'd0, BLANK ? 4'hF : l);
            end
        end
    endtask

    task automatic test_full_scan();
        run_scan(4'd0, 4'd9, 1'b0, 1'b1);
    endtask

    task automatic test_wrap();
        run_scan(4'd8, 4'd1, 1'b0, 1'b1);
        run_scan(4'd5, 4'd5, 1'b0, 1'b1);
    endtask

    task automatic test_stuck();
        run_scan(4'd0, 4'd9, 1'b1, 1'b1);
        stuck5 = 1'b0;
        run_scan(4'd3, 4'd7, 1'b0, 1'b1);
    endtask

    task automatic test_illegal();
        start = 1'b1;
        first = 4'hA;
        last  = 4'd3;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b1 ||
            err_digit !== 4'hF) begin
            errors++;
            $display("FAIL illegal: done=%b busy=%b err=%b ed=%h want 1 0 1 F",
                     done, busy, err, err_digit);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || err !== 1'b1) begin
            errors++;
            $display("FAIL illegal_after: done=%b busy=%b err=%b want 0 0 1",
                     done, busy, err);
        end
    endtask

    task automatic test_stop();
        stuck5 = 1'b0;
        start = 1'b1;
        first = 4'd0;
        last  = 4'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (2 * DWELL) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || bcd_out !== 4'd2 || err !== 1'b0) begin
            errors++;
            $display("FAIL stop_pre: busy=%b bcd=%h err=%b want 1 2 0",
                     busy, bcd_out, err);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || bcd_out !== 4'd2 || err !== 1'b0) begin
            errors++;
            $display("FAIL stop_done: done=%b busy=%b bcd=%h err=%b want 1 0 2 0",
                     done, busy, bcd_out, err);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 ||
            bcd_out !== (BLANK ? 4'hF : 4'd2)) begin
            errors++;
            $display("FAIL stop_idle: done=%b busy=%b bcd=%h want 0 0 %h",
                     done, busy, bcd_out, BLANK ? 4'hF : 4'd2);
        end
    endtask

    task automatic test_reset_mid();
        stuck5 = 1'b1;
        start = 1'b1;
        first = 4'd0;
        last  = 4'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (7 * DWELL) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || err !== 1'b1 || err_digit !== 4'd5) begin
            errors++;
            $display("FAIL rstmid_pre: busy=%b err=%b ed=%h want 1 1 5",
                     busy, err, err_digit);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (bcd_out !== 4'hF || busy !== 1'b0 || err !== 1'b0 ||
            done !== 1'b0 || err_digit !== 4'h0) begin
            errors++;
            $display("FAIL rstmid: bcd=%h busy=%b err=%b done=%b ed=%h want F 0 0 0 0",
                     bcd_out, busy, err, done, err_digit);
        end
        stuck5 = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_resume: busy=%b done=%b want 0 0", busy, done);
        end
        run_scan(4'd0, 4'd9, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        int ncyc;
        run_scan(4'd3, 4'd3, 1'b0, 1'b0);
        start = 1'b1;
        first = 4'd7;
        last  = 4'd8;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ignored: busy=%b done=%b want 0 0", busy, done);
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || bcd_out !== 4'd7 || err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_start: busy=%b bcd=%h err=%b want 1 7 0",
                     busy, bcd_out, err);
        end
        ncyc = 1;
        @(negedge clk);
        while (!done && ncyc < 100) begin
            ncyc++;
            @(negedge clk);
        end
        checks++;
        if (!done || ncyc != 2 * DWELL || bcd_out !== 4'd8) begin
            errors++;
            $display("FAIL b2b_done: done=%b cycles=%0d bcd=%h want 1 %0d 8",
                     done, ncyc, bcd_out, 2 * DWELL);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_full_scan();
        test_wrap();
        test_stuck();
        test_illegal();
        test_stop();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
